// File: rtl/vedic_mac_accum.sv
// Purpose: sums a frame of unsigned multiplier products into a wide accumulator; `VEDIC_MAC_SAT_EN` selects saturating instead of wrapping accumulation.
// Latency: out_valid rises on the edge that accepts the in_last product; one product per cycle within a frame.
// Backpressure: in_ready drops for the whole HOLD phase until out_ready consumes the result; in_ready decodes registered state only.
module vedic_mac_accum #(
    parameter int PROD_W = 32,
    parameter int ACC_W  = 48,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  count;
    logic              ovf;
    logic              accept;
    logic [ACC_W:0]    sum;
    logic              carry;
    logic [ACC_W-1:0]  acc_nxt;
    logic [CNT_W-1:0]  count_nxt;

    assign accept = in_valid && in_ready;
    assign sum    = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    assign carry  = sum[ACC_W];

`ifdef VEDIC_MAC_SAT_EN
    // once clamped, any further non-zero product carries again, so the clamp holds for the frame
    assign acc_nxt = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_nxt = sum[ACC_W-1:0];
`endif

    assign count_nxt = (&count) ? count : count + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_nxt = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        if (!rst && state != HOLD) begin
            in_ready = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
        end else if (accept) begin
            acc   <= acc_nxt;
            count <= count_nxt;
            ovf   <= ovf | carry;
            if (in_last) begin
                out_acc   <= acc_nxt;
                out_count <= count_nxt;
                out_ovf   <= ovf | carry;
                out_valid <= 1'b1;
            end
        end else if (state == HOLD && out_ready) begin
            // running frame state clears only once the result has been taken
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
        end
    end

endmodule
